// File: rtl/result_scoreboard_pkg.sv
// Shared definitions for the result scoreboard: FSM state encoding and the
// default parameter values used by the top level.
package result_scoreboard_pkg;

  typedef enum logic {
    ST_CHECK = 1'b0,
    ST_HALT  = 1'b1
  } state_e;

  localparam int DEF_WIDTH        = 32;
  localparam int DEF_DEPTH        = 4;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_TIMEOUT      = 64;
  localparam int DEF_STOP_ON_FAIL = 0;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational view of the head entry, so a
// pop and the use of the popped word happen in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage array: written on an accepted push, never reset.
  always_ff @(posedge Clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/result_scoreboard.sv
// Pairs DUT and reference result words in arrival order, compares them and
// keeps saturating tallies, first-mismatch capture and sticky error flags.
module result_scoreboard
  import result_scoreboard_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int STOP_ON_FAIL = DEF_STOP_ON_FAIL
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iDut_Valid,
  input  logic [WIDTH-1:0] iDut_Data,
  input  logic             iRef_Valid,
  input  logic [WIDTH-1:0] iRef_Data,
  output logic             oDut_Ready,
  output logic             oRef_Ready,
  output logic             oCompare_Valid,
  output logic             oMatch,
  output logic [CNT_W-1:0] oMatch_Count,
  output logic [CNT_W-1:0] oMismatch_Count,
  output logic [WIDTH-1:0] oFirst_Dut,
  output logic [WIDTH-1:0] oFirst_Ref,
  output logic             oError,
  output logic             oOverflow,
  output logic             oTimeout,
  output logic             oGood
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  // The wait counter stops at TIMEOUT, so it only needs to hold that value.
  localparam int               WAIT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

  logic             dut_full, dut_empty, ref_full, ref_empty;
  logic [WIDTH-1:0] dut_head, ref_head;
  logic             dut_push, ref_push, pop, pair_match, timeout_hit;

  state_e           state_q;
  logic             cmp_valid_q, match_q, error_q, overflow_q, timeout_q;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d, mismatch_cnt_q, mismatch_cnt_d;
  logic [WIDTH-1:0] first_dut_q, first_ref_q;
  logic [WAIT_W-1:0] wait_q, wait_d;

  // A word offered while its FIFO is full is dropped, even if a pop frees
  // space in the same cycle.
  assign dut_push   = iDut_Valid & ~dut_full;
  assign ref_push   = iRef_Valid & ~ref_full;
  assign pop        = (state_q == ST_CHECK) & ~dut_empty & ~ref_empty;
  assign pair_match = (dut_head == ref_head);

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut_fifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .push_i  (dut_push),
    .data_i  (iDut_Data),
    .pop_i   (pop),
    .data_o  (dut_head),
    .full_o  (dut_full),
    .empty_o (dut_empty)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ref_fifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .push_i  (ref_push),
    .data_i  (iRef_Data),
    .pop_i   (pop),
    .data_o  (ref_head),
    .full_o  (ref_full),
    .empty_o (ref_empty)
  );

  // Next values of the saturating tallies and the lone-word wait counter.
  always_comb begin
    match_cnt_d    = match_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    wait_d         = wait_q;
    if (pop) begin
      if (pair_match) begin
        if (match_cnt_q != CNT_MAX) match_cnt_d = match_cnt_q + 1'b1;
      end else begin
        if (mismatch_cnt_q != CNT_MAX) mismatch_cnt_d = mismatch_cnt_q + 1'b1;
      end
    end
    if (pop || (dut_empty && ref_empty)) begin
      wait_d = '0;
    end else if ((dut_empty != ref_empty) && (wait_q != WAIT_LIMIT)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (wait_d == WAIT_LIMIT);

  // CHECK/HALT state machine together with every registered result output.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q        <= ST_CHECK;
      cmp_valid_q    <= 1'b0;
      match_q        <= 1'b0;
      match_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      first_dut_q    <= '0;
      first_ref_q    <= '0;
      error_q        <= 1'b0;
      overflow_q     <= 1'b0;
      timeout_q      <= 1'b0;
      wait_q         <= '0;
    end else begin
      cmp_valid_q    <= pop;
      match_q        <= pop & pair_match;
      match_cnt_q    <= match_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      wait_q         <= wait_d;
      overflow_q     <= overflow_q | (iDut_Valid & dut_full) | (iRef_Valid & ref_full);
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
      if (pop && !pair_match) begin
        error_q <= 1'b1;
        if (!error_q) begin
          first_dut_q <= dut_head;
          first_ref_q <= ref_head;
        end
        if (STOP_ON_FAIL != 0) begin
          state_q <= ST_HALT;
        end
      end
    end
  end

  assign oDut_Ready      = ~dut_full;
  assign oRef_Ready      = ~ref_full;
  assign oCompare_Valid  = cmp_valid_q;
  assign oMatch          = match_q;
  assign oMatch_Count    = match_cnt_q;
  assign oMismatch_Count = mismatch_cnt_q;
  assign oFirst_Dut      = first_dut_q;
  assign oFirst_Ref      = first_ref_q;
  assign oError          = error_q;
  assign oOverflow       = overflow_q;
  assign oTimeout        = timeout_q;
  assign oGood           = (match_cnt_q != '0) & ~error_q & ~overflow_q & ~timeout_q;

endmodule

// File: tb/tb_result_scoreboard.sv
// Bench for result_scoreboard: instance u_a (defaults) is tracked every cycle
// by a queue-based reference model; instance u_b (CNT_W=2, TIMEOUT=8,
// STOP_ON_FAIL=1) is checked in directed scenarios against fixed values.
module tb_result_scoreboard;

  localparam int A_DEPTH = 4;
  localparam int A_TO    = 64;
  localparam int A_CMAX  = 65535;

  logic        Clock;
  logic        Reset;
  logic        iDut_Valid, iRef_Valid;
  logic [31:0] iDut_Data, iRef_Data;

  logic        a_dut_ready, a_ref_ready, a_cmp_valid, a_match;
  logic [15:0] a_match_cnt, a_mismatch_cnt;
  logic [31:0] a_first_dut, a_first_ref;
  logic        a_err, a_ovf, a_tmo, a_good;

  logic        b_dut_ready, b_ref_ready, b_cmp_valid, b_match;
  logic [1:0]  b_match_cnt, b_mismatch_cnt;
  logic [31:0] b_first_dut, b_first_ref;
  logic        b_err, b_ovf, b_tmo, b_good;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state for u_a
  logic [31:0] m_dq[$];
  logic [31:0] m_rq[$];
  bit          m_cmp_valid, m_match, m_err, m_ovf, m_tmo;
  int          m_match_cnt, m_mismatch_cnt, m_wait;
  logic [31:0] m_first_dut, m_first_ref;

  result_scoreboard #(.WIDTH(32), .DEPTH(A_DEPTH), .CNT_W(16), .TIMEOUT(A_TO), .STOP_ON_FAIL(0)) u_a (
    .Clock(Clock), .Reset(Reset),
    .iDut_Valid(iDut_Valid), .iDut_Data(iDut_Data),
    .iRef_Valid(iRef_Valid), .iRef_Data(iRef_Data),
    .oDut_Ready(a_dut_ready), .oRef_Ready(a_ref_ready),
    .oCompare_Valid(a_cmp_valid), .oMatch(a_match),
    .oMatch_Count(a_match_cnt), .oMismatch_Count(a_mismatch_cnt),
    .oFirst_Dut(a_first_dut), .oFirst_Ref(a_first_ref),
    .oError(a_err), .oOverflow(a_ovf), .oTimeout(a_tmo), .oGood(a_good)
  );

  result_scoreboard #(.WIDTH(32), .DEPTH(4), .CNT_W(2), .TIMEOUT(8), .STOP_ON_FAIL(1)) u_b (
    .Clock(Clock), .Reset(Reset),
    .iDut_Valid(iDut_Valid), .iDut_Data(iDut_Data),
    .iRef_Valid(iRef_Valid), .iRef_Data(iRef_Data),
    .oDut_Ready(b_dut_ready), .oRef_Ready(b_ref_ready),
    .oCompare_Valid(b_cmp_valid), .oMatch(b_match),
    .oMatch_Count(b_match_cnt), .oMismatch_Count(b_mismatch_cnt),
    .oFirst_Dut(b_first_dut), .oFirst_Ref(b_first_ref),
    .oError(b_err), .oOverflow(b_ovf), .oTimeout(b_tmo), .oGood(b_good)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] seq_word(input int k);
    return 32'(k) * 32'h9E3779B9;
  endfunction

  // One clock of the reference behaviour: pair heads in order, drop words
  // offered to a full queue, track how long a lone word has been waiting.
  task automatic model_step(input bit rst, input bit dv, input logic [31:0] dd,
                            input bit rv, input logic [31:0] rd);
    int dn;
    int rn;
    bit do_pop;
    logic [31:0] a;
    logic [31:0] b;
    if (rst) begin
      m_dq.delete(); m_rq.delete();
      m_cmp_valid = 0; m_match = 0; m_err = 0; m_ovf = 0; m_tmo = 0;
      m_match_cnt = 0; m_mismatch_cnt = 0; m_wait = 0;
      m_first_dut = '0; m_first_ref = '0;
      return;
    end
    dn = m_dq.size();
    rn = m_rq.size();
    do_pop = (dn > 0) && (rn > 0);
    m_cmp_valid = do_pop;
    m_match = 0;
    if (do_pop) begin
      a = m_dq.pop_front();
      b = m_rq.pop_front();
      m_match = (a == b);
      if (m_match) begin
        if (m_match_cnt < A_CMAX) m_match_cnt++;
      end else begin
        if (m_mismatch_cnt < A_CMAX) m_mismatch_cnt++;
        if (!m_err) begin m_first_dut = a; m_first_ref = b; end
        m_err = 1;
      end
    end
    if (dv) begin
      if (dn < A_DEPTH) m_dq.push_back(dd); else m_ovf = 1;
    end
    if (rv) begin
      if (rn < A_DEPTH) m_rq.push_back(rd); else m_ovf = 1;
    end
    if (do_pop || (dn == 0 && rn == 0)) m_wait = 0;
    else if ((dn == 0) != (rn == 0)) m_wait = (m_wait < A_TO) ? m_wait + 1 : m_wait;
    if (m_wait == A_TO) m_tmo = 1;
  endtask

  task automatic check_a();
    check("a_dut_ready", 64'(a_dut_ready), 64'(m_dq.size() < A_DEPTH));
    check("a_ref_ready", 64'(a_ref_ready), 64'(m_rq.size() < A_DEPTH));
    check("a_cmp_valid", 64'(a_cmp_valid), 64'(m_cmp_valid));
    check("a_match", 64'(a_match), 64'(m_match));
    check("a_match_cnt", 64'(a_match_cnt), 64'(m_match_cnt));
    check("a_mismatch_cnt", 64'(a_mismatch_cnt), 64'(m_mismatch_cnt));
    check("a_error", 64'(a_err), 64'(m_err));
    check("a_overflow", 64'(a_ovf), 64'(m_ovf));
    check("a_timeout", 64'(a_tmo), 64'(m_tmo));
    check("a_good", 64'(a_good), 64'((m_match_cnt > 0) && !m_err && !m_ovf && !m_tmo));
    check("a_first_dut", 64'(a_first_dut), 64'(m_first_dut));
    check("a_first_ref", 64'(a_first_ref), 64'(m_first_ref));
  endtask

  // Drive one cycle of inputs, clock, then check u_a against the model.
  task automatic cycle(input bit rst, input bit dv, input logic [31:0] dd,
                       input bit rv, input logic [31:0] rd);
    Reset = rst; iDut_Valid = dv; iDut_Data = dd; iRef_Valid = rv; iRef_Data = rd;
    @(posedge Clock);
    #1;
    model_step(rst, dv, dd, rv, rd);
    check_a();
    if (a_cmp_valid)
      $display("compare t=%0t match=%0b matches=%0d mismatches=%0d",
               $time, a_match, a_match_cnt, a_mismatch_cnt);
  endtask

  task automatic do_reset();
    cycle(1, 0, '0, 0, '0);
    cycle(1, 0, '0, 0, '0);
  endtask

  initial begin
    int pd;
    int pr;
    int dk;
    int rk;
    bit dv;
    bit rv;
    logic [31:0] dd;

    Reset = 1'b1; iDut_Valid = 0; iRef_Valid = 0; iDut_Data = '0; iRef_Data = '0;

    // reset state
    do_reset();
    check("b_rst_dut_ready", 64'(b_dut_ready), 64'd1);
    check("b_rst_ref_ready", 64'(b_ref_ready), 64'd1);
    check("b_rst_cmp_valid", 64'(b_cmp_valid), 64'd0);
    check("b_rst_good", 64'(b_good), 64'd0);
    check("b_rst_error", 64'(b_err), 64'd0);

    // DUT 5,7 at cycles 1,2; ref 5,7 at cycles 4,5 -> compares in cycles 6,7
    cycle(0, 1, 32'd5, 0, '0);
    cycle(0, 1, 32'd7, 0, '0);
    cycle(0, 0, '0, 0, '0);
    cycle(0, 0, '0, 1, 32'd5);
    check("s1_no_cmp_c5", 64'(a_cmp_valid), 64'd0);
    cycle(0, 0, '0, 1, 32'd7);
    check("s1_cmp_c6", 64'(a_cmp_valid), 64'd1);
    check("s1_match_c6", 64'(a_match), 64'd1);
    cycle(0, 0, '0, 0, '0);
    check("s1_cmp_c7", 64'(a_cmp_valid), 64'd1);
    check("s1_match_c7", 64'(a_match), 64'd1);
    check("s1_match_cnt", 64'(a_match_cnt), 64'd2);
    check("s1_good", 64'(a_good), 64'd1);
    cycle(0, 0, '0, 0, '0);
    check("s1_no_cmp_c8", 64'(a_cmp_valid), 64'd0);

    // five DUT words, no reference words
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      cycle(0, 1, 32'(i), 0, '0);
      if (i == 4) begin
        check("s3_ready_after4", 64'(a_dut_ready), 64'd0);
        check("s3_no_ovf_after4", 64'(a_ovf), 64'd0);
      end
    end
    check("s3_overflow", 64'(a_ovf), 64'd1);
    check("s3_good", 64'(a_good), 64'd0);

    // reset landing on a pop cycle
    do_reset();
    cycle(0, 1, 32'd9, 1, 32'd9);
    cycle(0, 1, 32'd3, 1, 32'd3);
    check("s6_cnt_before", 64'(a_match_cnt), 64'd1);
    cycle(1, 0, '0, 0, '0);
    check("s6_cmp_valid", 64'(a_cmp_valid), 64'd0);
    check("s6_match_cnt", 64'(a_match_cnt), 64'd0);
    check("s6_mismatch_cnt", 64'(a_mismatch_cnt), 64'd0);
    check("s6_dut_ready", 64'(a_dut_ready), 64'd1);
    check("s6_ref_ready", 64'(a_ref_ready), 64'd1);

    // mismatch halts u_b
    do_reset();
    cycle(0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEE);
    check("s2_no_cmp_yet", 64'(b_cmp_valid), 64'd0);
    cycle(0, 0, '0, 0, '0);
    check("s2_cmp_valid", 64'(b_cmp_valid), 64'd1);
    check("s2_match", 64'(b_match), 64'd0);
    check("s2_error", 64'(b_err), 64'd1);
    check("s2_mismatch_cnt", 64'(b_mismatch_cnt), 64'd1);
    check("s2_first_dut", 64'(b_first_dut), 64'hDEADBEEF);
    check("s2_first_ref", 64'(b_first_ref), 64'hDEADBEEE);
    cycle(0, 1, 32'h11, 1, 32'h11);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, '0, 0, '0);
      check("s2_halt_no_cmp", 64'(b_cmp_valid), 64'd0);
    end
    check("s2_halt_match_cnt", 64'(b_match_cnt), 64'd0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 32'h22, 1, 32'h22);
    check("s2_halt_fills", 64'(b_dut_ready), 64'd0);
    check("s2_first_hold", 64'(b_first_dut), 64'hDEADBEEF);

    // match counter saturation at 3 on u_b
    do_reset();
    for (int i = 0; i < 5; i++) cycle(0, 1, 32'(100 + i), 1, 32'(100 + i));
    cycle(0, 0, '0, 0, '0);
    cycle(0, 0, '0, 0, '0);
    check("s5_match_sat", 64'(b_match_cnt), 64'd3);
    check("s5_mismatch", 64'(b_mismatch_cnt), 64'd0);
    check("s5_good", 64'(b_good), 64'd1);

    // lone DUT word times out on u_b eight cycles after the push
    do_reset();
    cycle(0, 1, 32'h42, 0, '0);
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, '0, 0, '0);
      check("s4_timeout", 64'(b_tmo), 64'(i == 8));
    end
    check("s4_good", 64'(b_good), 64'd0);

    // randomized traffic on u_a with shifting arrival rates
    do_reset();
    dk = 0;
    rk = 0;
    for (int blk = 0; blk < 6; blk++) begin
      pd = 30 + 20 * (blk % 3);
      pr = 70 - 20 * (blk % 3);
      for (int c = 0; c < 50; c++) begin
        dv = ($urandom_range(0, 99) < pd);
        rv = ($urandom_range(0, 99) < pr);
        dd = seq_word(dk) ^ (($urandom_range(0, 9) == 0) ? 32'h1 : 32'h0);
        cycle(0, dv, dd, rv, seq_word(rk));
        if (dv) dk++;
        if (rv) rk++;
      end
    end
    for (int c = 0; c < 10; c++) cycle(0, 0, '0, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_scoreboard.md
RESULT_SCOREBOARD -- requirements
Module: result_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 32, compared data width.
REQ-002 SHALL have parameter DEPTH, default 4, per-stream FIFO depth; power of two, >= 2.
REQ-003 SHALL have parameter CNT_W, default 16, width of the match and mismatch counters.
REQ-004 SHALL have parameter TIMEOUT, default 64, cycles a lone unpaired word may wait; 0 disables the timeout check.
REQ-005 SHALL have parameter STOP_ON_FAIL, default 0, halts comparison on the first mismatch when 1.
REQ-006 SHALL have port Clock  input  1  clock, rising edge.
REQ-007 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port iDut_Valid  input  1  DUT result word present.
REQ-009 SHALL have port iDut_Data  input  WIDTH  DUT result word.
REQ-010 SHALL have port iRef_Valid  input  1  reference result word present.
REQ-011 SHALL have port iRef_Data  input  WIDTH  reference result word.
REQ-012 SHALL have ports oDut_Ready and oRef_Ready  output  1  corresponding FIFO not full.
REQ-013 SHALL have port oCompare_Valid  output  1  one-cycle pulse, a comparison result is present.
REQ-014 SHALL have port oMatch  output  1  result of that comparison, qualified by oCompare_Valid.
REQ-015 SHALL have ports oMatch_Count and oMismatch_Count  output  CNT_W  saturating totals.
REQ-016 SHALL have ports oFirst_Dut and oFirst_Ref  output  WIDTH  operands of the first mismatch.
REQ-017 SHALL have ports oError, oOverflow and oTimeout  output  1  sticky flags.
REQ-018 SHALL have port oGood  output  1  at least one match, and oError, oOverflow and oTimeout all 0.

Function
REQ-019 Each stream SHALL push into its own FIFO when Valid=1 and Ready=1.
REQ-020 A Valid=1 while Ready=0 SHALL drop the word and set oOverflow; a same-cycle pop does not rescue the word.
REQ-021 In state CHECK with both FIFOs non-empty, one word SHALL be popped from each FIFO in the same cycle.
REQ-022 oCompare_Valid SHALL pulse on the cycle after the pop, with oMatch = (dut word == ref word) over the full WIDTH.
REQ-023 Latency SHALL be 2 cycles from acceptance of the later word of a pair to oCompare_Valid.
REQ-024 Pairing SHALL be in strict FIFO order: the Nth DUT word is compared with the Nth reference word.
REQ-025 Sustained throughput SHALL be one comparison per cycle.
REQ-026 On a match, oMatch_Count SHALL increment; on a mismatch, oMismatch_Count SHALL increment and oError SHALL set. Both counters saturate at 2^CNT_W-1.
REQ-027 oFirst_Dut and oFirst_Ref SHALL load only on the first mismatch after reset and hold afterwards.
REQ-028 The FSM SHALL have two states, CHECK and HALT.
REQ-029 CHECK SHALL go to HALT on a mismatch when STOP_ON_FAIL=1; HALT is left only by Reset.
REQ-030 In HALT: no pops and no compares; pushes continue until the FIFOs are full.
REQ-031 The wait counter SHALL increment while exactly one FIFO is non-empty.
REQ-032 The wait counter SHALL clear on a pop or when both FIFOs are empty.
REQ-033 When the wait counter reaches TIMEOUT (if TIMEOUT != 0), oTimeout SHALL set.

Reset
REQ-034 On Reset, the FIFOs SHALL be emptied, the state SHALL be CHECK, and the wait counter SHALL be 0.
REQ-035 On Reset, all outputs SHALL be 0 except oDut_Ready=1 and oRef_Ready=1.
REQ-036 Reset asserted mid-stream SHALL discard any in-flight comparison: no oCompare_Valid pulse in the cycle after Reset.

Structure
REQ-037 Package result_scoreboard_pkg SHALL hold the CHECK/HALT state encoding and the default parameter values.
REQ-038 Both FIFOs SHALL be instances of one sub-module, sync_fifo (parameters WIDTH, DEPTH), which provides full and empty outputs.

Verification
REQ-039 Scenario: DUT words 5,7 at cycles 1,2; ref words 5,7 at cycles 4,5 -> compare pulses at cycles 6,7, oMatch=1 each, oMatch_Count=2, oGood=1.
REQ-040 Scenario: DUT 0xDEADBEEF vs ref 0xDEADBEEE, STOP_ON_FAIL=1 -> oError=1, oFirst_Dut=0xDEADBEEF, oFirst_Ref=0xDEADBEEE, state HALT; a following matching pair is not compared.
REQ-041 Scenario: DEPTH=4, 5 DUT words pushed with no ref words -> oDut_Ready=0 after the 4th word, oOverflow=1, oGood=0.
REQ-042 Scenario: TIMEOUT=8, one DUT word and no ref word -> oTimeout=1 eight cycles after the push.
REQ-043 Scenario: CNT_W=2, 5 matching pairs -> oMatch_Count saturates at 3.
REQ-044 Scenario: Reset during a pop cycle -> next cycle oCompare_Valid=0, all counters 0, both Ready outputs 1.
